// File: rtl/figure_scheduler_if.sv
// Command/status bundle between the motion-command decoder and the figure scheduler.
// The scheduler takes the slave view; whatever sources commands takes the master view.
interface figure_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       estop;
  logic [2:0] figure;
  logic       cmd_ack;
  logic       cmd_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd, estop,
    input  figure, cmd_ack, cmd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd, estop,
    output figure, cmd_ack, cmd_err, busy
  );
endinterface

// File: rtl/figure_scheduler.sv
// Chooses the 8x8 figure shown by the dot-matrix driver from decoded motion commands,
// with turn blinking, link-loss timeout, emergency stop and frame-aligned figure updates.
module figure_scheduler #(
  parameter int TIMEOUT_MS = 2000,
  parameter int STOP_MS    = 1000,
  parameter int BLINK_MS   = 250,
  parameter int CNT_W      = 16
) (
  input logic               clk_1k,
  input logic               rst_n,
  figure_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_BLINK,
    S_STOP_HOLD,
    S_ESTOP
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(STOP_MS - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_MS - 1);
  localparam logic [2:0]       FIG_BLANK    = 3'd7;
  localparam logic [2:0]       FIG_STOP     = 3'd3;
  localparam logic [2:0]       CMD_MAX      = 3'd4;

  state_t           state_q, state_d;
  logic [2:0]       scan_phase_q, scan_phase_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [2:0]       last_cmd_q, last_cmd_d;
  logic [2:0]       figure_q, figure_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             cmd_err_q, cmd_err_d;
  logic [2:0]       target_fig;
  logic             cmd_legal;
  logic             accept;

  always_comb begin
    state_d      = state_q;
    scan_phase_d = scan_phase_q + 3'd1;
    idle_cnt_d   = idle_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    last_cmd_d   = last_cmd_q;
    figure_d     = figure_q;
    target_fig   = FIG_BLANK;

    // estop masks the command strobe entirely: no ack, no err, no accept.
    cmd_legal = (bus.cmd <= CMD_MAX);
    accept    = bus.cmd_valid & ~bus.estop & cmd_legal;
    cmd_ack_d = accept;
    cmd_err_d = bus.cmd_valid & ~bus.estop & ~cmd_legal;

    unique case (state_q)
      S_SHOW:      target_fig = last_cmd_q;
      S_BLINK:     target_fig = blink_on_q ? last_cmd_q : FIG_BLANK;
      S_STOP_HOLD: target_fig = FIG_STOP;
      S_ESTOP:     target_fig = FIG_STOP;
      default:     target_fig = FIG_BLANK;
    endcase

    // Only swap figures on the last scan column so the driver never shows a torn frame.
    if (scan_phase_q == 3'd7)
      figure_d = target_fig;

    if (state_q == S_BLINK) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_SHOW, S_BLINK: begin
        if (idle_cnt_q == TIMEOUT_LAST) begin
          state_d    = S_STOP_HOLD;
          stop_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      S_STOP_HOLD: begin
        if (stop_cnt_q == STOP_LAST)
          state_d = S_IDLE;
        else
          stop_cnt_d = stop_cnt_q + 1'b1;
      end
      S_ESTOP: begin
        if (!bus.estop) begin
          state_d    = S_STOP_HOLD;
          stop_cnt_d = '0;
        end
      end
      default: ;
    endcase

    // An accepted command outranks a same-cycle timeout or stop-hold expiry.
    if (accept) begin
      last_cmd_d = bus.cmd;
      idle_cnt_d = '0;
      state_d    = (bus.cmd <= 3'd1) ? S_BLINK : S_SHOW;
      if (bus.cmd != last_cmd_q) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end
    end

    if (bus.estop)
      state_d = S_ESTOP;
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scan_phase_q <= '0;
      idle_cnt_q   <= '0;
      stop_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      last_cmd_q   <= FIG_BLANK;
      figure_q     <= FIG_BLANK;
      cmd_ack_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_phase_q <= scan_phase_d;
      idle_cnt_q   <= idle_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      last_cmd_q   <= last_cmd_d;
      figure_q     <= figure_d;
      cmd_ack_q    <= cmd_ack_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.figure  = figure_q;
  assign bus.cmd_ack = cmd_ack_q;
  assign bus.cmd_err = cmd_err_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_figure_scheduler.sv
// Bench for figure_scheduler: directed vector table, hand-written blink/estop/reset
// sequences, and randomized traffic checked cycle by cycle against a time-based model.
module tb_figure_scheduler;

  localparam int T_MS = 40;
  localparam int S_MS = 20;
  localparam int B_MS = 8;

  localparam int MD_IDLE  = 0;
  localparam int MD_SHOW  = 1;
  localparam int MD_BLINK = 2;
  localparam int MD_STOP  = 3;
  localparam int MD_ESTOP = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   edge_n;

  figure_scheduler_if bus ();

  figure_scheduler #(
    .TIMEOUT_MS(T_MS),
    .STOP_MS   (S_MS),
    .BLINK_MS  (B_MS),
    .CNT_W     (16)
  ) dut (
    .clk_1k(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: modes plus elapsed-time counters; blink phase from tick division.
  typedef struct {
    int mode;
    int last;
    int age;
    int stop_age;
    int bticks;
    int cyc;
    int fig;
    int ack;
    int err;
  } model_t;

  localparam model_t MODEL_RST = '{mode: MD_IDLE, last: 7, age: 0, stop_age: 0,
                                   bticks: 0, cyc: 0, fig: 7, ack: 0, err: 0};

  model_t m;

  function automatic model_t model_step(model_t cur, logic v, logic [2:0] c, logic e);
    model_t nx;
    int     tgt;
    bit     acc;
    nx     = cur;
    nx.cyc = cur.cyc + 1;
    case (cur.mode)
      MD_SHOW:  tgt = cur.last;
      MD_BLINK: tgt = (((cur.bticks / B_MS) % 2) == 0) ? cur.last : 7;
      MD_STOP:  tgt = 3;
      MD_ESTOP: tgt = 3;
      default:  tgt = 7;
    endcase
    if ((cur.cyc % 8) == 7) nx.fig = tgt;
    acc    = v && !e && (c <= 3'd4);
    nx.ack = acc ? 1 : 0;
    nx.err = (v && !e && (c > 3'd4)) ? 1 : 0;
    if (cur.mode == MD_BLINK) nx.bticks = cur.bticks + 1;
    if (e) begin
      nx.mode = MD_ESTOP;
    end else if (acc) begin
      if (int'(c) != cur.last) nx.bticks = 0;
      nx.last = int'(c);
      nx.age  = 0;
      nx.mode = (c <= 3'd1) ? MD_BLINK : MD_SHOW;
    end else begin
      case (cur.mode)
        MD_SHOW, MD_BLINK: begin
          if (cur.age + 1 >= T_MS) begin
            nx.mode     = MD_STOP;
            nx.stop_age = 0;
          end else nx.age = cur.age + 1;
        end
        MD_STOP: begin
          if (cur.stop_age + 1 >= S_MS) nx.mode = MD_IDLE;
          else nx.stop_age = cur.stop_age + 1;
        end
        MD_ESTOP: begin
          nx.mode     = MD_STOP;
          nx.stop_age = 0;
        end
        default: ;
      endcase
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MODEL_RST;
    else        m <= model_step(m, bus.cmd_valid, bus.cmd, bus.estop);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_figure", 32'(bus.figure), 32'(m.fig));
    check("model_ack",    32'(bus.cmd_ack), 32'(m.ack));
    check("model_err",    32'(bus.cmd_err), 32'(m.err));
    check("model_busy",   32'(bus.busy), (m.mode != MD_IDLE) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic e);
    bus.cmd_valid = v;
    bus.cmd       = c;
    bus.estop     = e;
    @(posedge clk);
    #1;
    edge_n++;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    check_model();
  endtask

  task automatic check_outputs(input string name, input int fig, input int ack,
                               input int err, input int busy);
    check({name, "_figure"}, 32'(bus.figure), 32'(fig));
    check({name, "_ack"},    32'(bus.cmd_ack), 32'(ack));
    check({name, "_err"},    32'(bus.cmd_err), 32'(err));
    check({name, "_busy"},   32'(bus.busy), 32'(busy));
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.estop     = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("reset", 7, 0, 0, 0);
    #2;
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  typedef struct {
    string      name;
    logic       v;
    logic [2:0] cmd;
    int         idle;
    int         fig;
    int         ack;
    int         err;
    int         busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    edge_n        = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.estop     = 1'b0;

    // Edge numbers count from reset release; the strobe is sampled on the entry's first edge.
    tbl[0]  = '{"idle_after_reset", 1'b0, 3'd0, 2,  7, 0, 0, 0};  // edge 3, phase 3
    tbl[1]  = '{"accept_straight",  1'b1, 3'd2, 0,  7, 1, 0, 1};  // edge 4
    tbl[2]  = '{"before_frame",     1'b0, 3'd0, 2,  7, 0, 0, 1};  // edge 7
    tbl[3]  = '{"frame_load",       1'b0, 3'd0, 0,  2, 0, 0, 1};  // edge 8
    tbl[4]  = '{"illegal_cmd",      1'b1, 3'd6, 0,  2, 0, 1, 1};  // edge 9
    tbl[5]  = '{"show_steady",      1'b0, 3'd0, 33, 2, 0, 0, 1};  // edge 43
    tbl[6]  = '{"accept_at_timeout",1'b1, 3'd2, 0,  2, 1, 0, 1};  // edge 44
    tbl[7]  = '{"show_until_to",    1'b0, 3'd0, 39, 2, 0, 0, 1};  // edge 84
    tbl[8]  = '{"stop_figure",      1'b0, 3'd0, 3,  3, 0, 0, 1};  // edge 88
    tbl[9]  = '{"stop_hold_last",   1'b0, 3'd0, 14, 3, 0, 0, 1};  // edge 103
    tbl[10] = '{"enter_idle",       1'b0, 3'd0, 0,  3, 0, 0, 0};  // edge 104
    tbl[11] = '{"blank_figure",     1'b0, 3'd0, 7,  7, 0, 0, 0};  // edge 112
    tbl[12] = '{"accept_reverse",   1'b1, 3'd4, 0,  7, 1, 0, 1};  // edge 113
    tbl[13] = '{"reverse_figure",   1'b0, 3'd0, 6,  4, 0, 0, 1};  // edge 120

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].cmd, 1'b0);
      repeat (tbl[i].idle) step(1'b0, 3'd0, 1'b0);
      check_outputs(tbl[i].name, tbl[i].fig, tbl[i].ack, tbl[i].err, tbl[i].busy);
    end

    // Left blink, refreshed every 30 cycles: 0/7 alternation never restarts or times out.
    do_reset();
    while (edge_n < 120) begin
      int nxt;
      nxt = edge_n + 1;
      step((nxt == 8) || (nxt == 38) || (nxt == 68) || (nxt == 98), 3'd0, 1'b0);
      if (edge_n >= 16 && ((edge_n - 16) % 4) == 0)
        check("blink_figure", 32'(bus.figure), (((edge_n - 16) / 8) % 2 == 0) ? 32'd0 : 32'd7);
    end

    // Emergency stop while blinking right; a strobe during estop is ignored.
    do_reset();
    while (edge_n < 60) begin
      int nxt;
      nxt = edge_n + 1;
      step((nxt == 8) || (nxt == 18), (nxt == 18) ? 3'd2 : 3'd1, (nxt >= 13) && (nxt <= 30));
      case (edge_n)
        16: check_outputs("estop_frame", 3, 0, 0, 1);
        18: check_outputs("estop_cmd_ignored", 3, 0, 0, 1);
        50: check_outputs("estop_stop_hold", 3, 0, 0, 1);
        51: check_outputs("estop_to_idle", 3, 0, 0, 0);
        55: check("estop_fig_held", 32'(bus.figure), 32'd3);
        56: check("estop_fig_blank", 32'(bus.figure), 32'd7);
        default: ;
      endcase
    end

    // Asynchronous reset between edges while blinking with an ack pending.
    do_reset();
    while (edge_n < 20) begin
      int nxt;
      nxt = edge_n + 1;
      step((nxt == 8) || (nxt == 20), 3'd1, 1'b0);
      if (edge_n == 16) check("pre_reset_blink", 32'(bus.figure), 32'd1);
    end
    check("pre_reset_ack", 32'(bus.cmd_ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 7, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    edge_n = 0;
    while (edge_n < 8) begin
      int nxt;
      nxt = edge_n + 1;
      step(nxt == 4, 3'd2, 1'b0);
      if (edge_n == 7) check("phase_restart_hold", 32'(bus.figure), 32'd7);
      if (edge_n == 8) check("phase_restart_load", 32'(bus.figure), 32'd2);
    end

    // Randomized traffic with dense, sparse and near-silent command rates.
    do_reset();
    begin
      logic e_lvl;
      e_lvl = 1'b0;
      for (int blk = 0; blk < 15; blk++) begin
        int thr;
        thr = (blk % 3 == 0) ? 250 : ((blk % 3 == 1) ? 20 : 2);
        for (int k = 0; k < 200; k++) begin
          logic       v;
          logic [2:0] c;
          if (blk % 2 == 1 && $urandom_range(79) == 0) e_lvl = ~e_lvl;
          if (blk % 2 == 0) e_lvl = 1'b0;
          v = ($urandom_range(999) < thr);
          c = 3'($urandom_range(7));
          step(v, c, e_lvl);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
